alien_formation_mover: RTL and testbench

- Upstream of the bullet/collision stage: owns the alien formation's top-left anchor (Aliens_Row, Aliens_Col) and marches it across the 640x480 playfield.
- Consumes the 50-bit alive grid fed back from the collision stage to find the occupied extents.
- Classic march: steps sideways, drops and reverses at an edge, speeds up as aliens die.
- Flags invasion when the lowest live row reaches the player.

---
 rtl/alien_formation_mover_pkg.sv | 37 +++
 rtl/alien_formation_mover_grid_extents.sv | 38 +++
 rtl/alien_formation_mover.sv | 112 +++++++++++
 tb/tb_alien_formation_mover.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alien_formation_mover_pkg.sv
// Shared playfield/grid geometry and state encoding for the alien formation stages.
package alien_formation_mover_pkg;

  localparam int unsigned NUM_ROWS   = 5;
  localparam int unsigned NUM_COLS   = 10;
  localparam int unsigned NUM_ALIENS = NUM_ROWS * NUM_COLS;

  localparam int unsigned ALIEN_W  = 30;
  localparam int unsigned ALIEN_H  = 20;
  localparam int unsigned PITCH_X  = 40;
  localparam int unsigned PITCH_Y  = 30;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam int unsigned ROW_W     = 9;
  localparam int unsigned COL_W     = 10;
  localparam int unsigned EXT_W     = 11;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned COL_IDX_W = 4;
  localparam int unsigned ROW_IDX_W = 3;
  localparam int unsigned ALIVE_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [COL_IDX_W-1:0] lmost;
    logic [COL_IDX_W-1:0] rmost;
    logic [ROW_IDX_W-1:0] bmost;
    logic [ALIVE_W-1:0]   alive;
    logic                 empty;
  } extents_t;

endpackage

// File: rtl/alien_formation_mover_grid_extents.sv
// Occupied extents and live count of the alien grid; purely combinational.
module alien_formation_mover_grid_extents
  import alien_formation_mover_pkg::*;
(
  input  logic [NUM_ALIENS-1:0] grid,
  output extents_t              extents_c
);

  logic [NUM_COLS-1:0] colmask;
  logic [NUM_ROWS-1:0] rowmask;

  // Collapse the grid onto its column and row axes.
  always_comb begin
    colmask = '0;
    rowmask = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      colmask    = colmask | grid[r*NUM_COLS +: NUM_COLS];
      rowmask[r] = |grid[r*NUM_COLS +: NUM_COLS];
    end
  end

  // Scan directions pick the lowest (left) and highest (right/bottom) set index.
  always_comb begin
    extents_c = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (colmask[NUM_COLS-1-c]) extents_c.lmost = COL_IDX_W'(NUM_COLS-1-c);
      if (colmask[c])            extents_c.rmost = COL_IDX_W'(c);
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (rowmask[r]) extents_c.bmost = ROW_IDX_W'(r);
    end
    for (int i = 0; i < NUM_ALIENS; i++) begin
      extents_c.alive = extents_c.alive + ALIVE_W'(grid[i]);
    end
    extents_c.empty = ~|grid;
  end

endmodule

// File: rtl/alien_formation_mover.sv
// Marches the alien formation anchor across the playfield: side steps, edge drops,
// speed-up as aliens die, and sticky invaded/cleared end conditions.
module alien_formation_mover
  import alien_formation_mover_pkg::*;
#(
  parameter int unsigned START_ROW        = 40,
  parameter int unsigned START_COL        = 20,
  parameter int unsigned STEP_X           = 10,
  parameter int unsigned STEP_Y           = 10,
  parameter int unsigned PERIOD_MIN       = 50000,
  parameter int unsigned PERIOD_PER_ALIEN = 20000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [NUM_ALIENS-1:0] Aliens_Grid,
  input  logic [ROW_W-1:0]      Player_Row,
  output logic [ROW_W-1:0]      Aliens_Row,
  output logic [COL_W-1:0]      Aliens_Col,
  output logic                  Moving_Right,
  output logic                  Step_Pulse,
  output logic                  Invaded,
  output logic                  Cleared
);

  state_e           state;
  logic [CNT_W-1:0] count;

  extents_t         extents_c;
  logic [EXT_W-1:0] right_edge_c;
  logic [EXT_W-1:0] left_edge_c;
  logic [EXT_W-1:0] bottom_c;
  logic [EXT_W-1:0] drop_sum_c;
  logic [ROW_W-1:0] row_drop_c;
  logic             hit_right_c;
  logic             hit_left_c;
  logic [CNT_W-1:0] period_c;

  alien_formation_mover_grid_extents u_extents (
    .grid      (Aliens_Grid),
    .extents_c (extents_c)
  );

  // Pixel extents in 11 bits so edge sums never wrap; period shrinks with each kill.
  always_comb begin
    right_edge_c = EXT_W'(Aliens_Col) + EXT_W'(extents_c.rmost) * EXT_W'(PITCH_X) + EXT_W'(ALIEN_W);
    left_edge_c  = EXT_W'(Aliens_Col) + EXT_W'(extents_c.lmost) * EXT_W'(PITCH_X);
    bottom_c     = EXT_W'(Aliens_Row) + EXT_W'(extents_c.bmost) * EXT_W'(PITCH_Y) + EXT_W'(ALIEN_H);
    hit_right_c  = (right_edge_c + EXT_W'(STEP_X)) > EXT_W'(SCREEN_W);
    hit_left_c   = left_edge_c < EXT_W'(STEP_X);
    drop_sum_c   = EXT_W'(Aliens_Row) + EXT_W'(STEP_Y);
    row_drop_c   = (drop_sum_c > EXT_W'(SCREEN_H - 1)) ? ROW_W'(SCREEN_H - 1) : ROW_W'(drop_sum_c);
    period_c     = CNT_W'(PERIOD_MIN) + CNT_W'(extents_c.alive) * CNT_W'(PERIOD_PER_ALIEN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      Aliens_Row   <= ROW_W'(START_ROW);
      Aliens_Col   <= COL_W'(START_COL);
      Moving_Right <= 1'b1;
      Step_Pulse   <= 1'b0;
      Invaded      <= 1'b0;
      Cleared      <= 1'b0;
    end else begin
      Step_Pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) state <= ST_MARCH;
        end
        ST_MARCH: begin
          // End conditions outrank a step landing on the same cycle.
          if (extents_c.empty) begin
            Cleared <= 1'b1;
            state   <= ST_DONE;
          end else if (bottom_c >= EXT_W'(Player_Row)) begin
            Invaded <= 1'b1;
            state   <= ST_DONE;
          end else if (count >= period_c) begin
            count      <= '0;
            Step_Pulse <= 1'b1;
            if (Moving_Right) begin
              if (hit_right_c) begin
                Aliens_Row   <= row_drop_c;
                Moving_Right <= 1'b0;
              end else begin
                Aliens_Col <= Aliens_Col + COL_W'(STEP_X);
              end
            end else begin
              if (hit_left_c) begin
                Aliens_Row   <= row_drop_c;
                Moving_Right <= 1'b1;
              end else begin
                Aliens_Col <= Aliens_Col - COL_W'(STEP_X);
              end
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alien_formation_mover.sv
// Bench for alien_formation_mover: cycle model feeding a scoreboard queue plus directed march scenarios.
module tb_alien_formation_mover;

  localparam int PMIN = 4;
  localparam int PPA  = 1;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [49:0] Aliens_Grid;
  logic [8:0]  Player_Row;
  logic [8:0]  Aliens_Row;
  logic [9:0]  Aliens_Col;
  logic        Moving_Right;
  logic        Step_Pulse;
  logic        Invaded;
  logic        Cleared;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int row;
    int col;
    int right;
    int pulse;
    int invaded;
    int cleared;
  } exp_t;

  exp_t exp_q[$];

  // Model state: 0 idle, 1 march, 2 done
  int m_row, m_col, m_right, m_pulse, m_inv, m_clr, m_cnt, m_state;

  alien_formation_mover #(
    .PERIOD_MIN       (PMIN),
    .PERIOD_PER_ALIEN (PPA)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .Aliens_Grid  (Aliens_Grid),
    .Player_Row   (Player_Row),
    .Aliens_Row   (Aliens_Row),
    .Aliens_Col   (Aliens_Col),
    .Moving_Right (Moving_Right),
    .Step_Pulse   (Step_Pulse),
    .Invaded      (Invaded),
    .Cleared      (Cleared)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int drop_row(input int row);
    return (row + 10 > 479) ? 479 : row + 10;
  endfunction

  task automatic model_step();
    int lm, rm, bm, al;
    exp_t e;
    lm = -1; rm = -1; bm = -1; al = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 10; c++)
        if (Aliens_Grid[r*10+c]) begin
          al++;
          if (lm < 0 || c < lm) lm = c;
          if (c > rm) rm = c;
          if (r > bm) bm = r;
        end
    if (Reset) begin
      m_row = 40; m_col = 20; m_right = 1; m_pulse = 0;
      m_inv = 0; m_clr = 0; m_cnt = 0; m_state = 0;
    end else begin
      m_pulse = 0;
      if (m_state == 0) begin
        if (Start) m_state = 1;
      end else if (m_state == 1) begin
        if (al == 0) begin
          m_clr = 1; m_state = 2;
        end else if (m_row + bm*30 + 20 >= int'(Player_Row)) begin
          m_inv = 1; m_state = 2;
        end else if (m_cnt >= PMIN + al*PPA) begin
          m_cnt = 0;
          m_pulse = 1;
          if (m_right != 0) begin
            if (m_col + rm*40 + 30 + 10 > 640) begin
              m_row = drop_row(m_row); m_right = 0;
            end else m_col = m_col + 10;
          end else begin
            if (m_col + lm*40 < 10) begin
              m_row = drop_row(m_row); m_right = 1;
            end else m_col = m_col - 10;
          end
        end else m_cnt = m_cnt + 1;
      end
    end
    e.row = m_row; e.col = m_col; e.right = m_right;
    e.pulse = m_pulse; e.invaded = m_inv; e.cleared = m_clr;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  // Scoreboard: compare every settled cycle against the model entry for that edge.
  initial forever begin
    exp_t e;
    @(negedge Clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_value("sb_row", 32'(Aliens_Row), e.row);
      check_value("sb_col", 32'(Aliens_Col), e.col);
      check_value("sb_right", 32'(Moving_Right), e.right);
      check_value("sb_pulse", 32'(Step_Pulse), e.pulse);
      check_value("sb_invaded", 32'(Invaded), e.invaded);
      check_value("sb_cleared", 32'(Cleared), e.cleared);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge Clk);
      n++;
      if (Step_Pulse) return;
    end
    check_value("pulse_timeout", 0, 1);
  endtask

  task automatic march_to_col(input int col, input int max_steps);
    int n;
    for (int i = 0; i < max_steps && int'(Aliens_Col) != col; i++) wait_pulse(200, n);
    check_value("reach_col", 32'(Aliens_Col), col);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge Clk);
      if (Step_Pulse) pulses++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    logic [49:0] col0;
    Reset = 1'b1; Start = 1'b0; Aliens_Grid = '1; Player_Row = 9'd479;
    repeat (2) @(negedge Clk);
    check_value("rst_row", 32'(Aliens_Row), 40);
    check_value("rst_col", 32'(Aliens_Col), 20);
    check_value("rst_right", 32'(Moving_Right), 1);
    check_value("rst_flags", {Step_Pulse, Invaded, Cleared}, 0);

    // Full grid: first step after PMIN + 50 clocks in MARCH.
    Reset = 1'b0; Start = 1'b1;
    @(negedge Clk);
    wait_pulse(200, n);
    check_value("first_step_latency", n, 55);
    check_value("first_step_col", 32'(Aliens_Col), 30);
    check_value("first_step_row", 32'(Aliens_Row), 40);

    march_to_col(250, 40);
    check_value("edge_pre_row", 32'(Aliens_Row), 40);
    wait_pulse(200, n);
    check_value("drop_row", 32'(Aliens_Row), 50);
    check_value("drop_col", 32'(Aliens_Col), 250);
    check_value("drop_dir", 32'(Moving_Right), 0);
    wait_pulse(200, n);
    check_value("left_step_col", 32'(Aliens_Col), 240);

    // Reset mid-march.
    march_to_col(130, 20);
    repeat (3) @(negedge Clk);
    Start = 1'b0; Reset = 1'b1;
    @(negedge Clk);
    check_value("midrst_col", 32'(Aliens_Col), 20);
    check_value("midrst_row", 32'(Aliens_Row), 40);
    check_value("midrst_dir", 32'(Moving_Right), 1);
    check_value("midrst_flags", {Step_Pulse, Invaded, Cleared}, 0);
    Reset = 1'b0;
    count_pulses(80, pulses);
    check_value("idle_no_step", pulses, 0);
    check_value("idle_hold_col", 32'(Aliens_Col), 20);

    // Only column 0 alive: right drop at 610, left drop at col 0.
    col0 = '0;
    for (int r = 0; r < 5; r++) col0[r*10] = 1'b1;
    Aliens_Grid = col0; Start = 1'b1;
    march_to_col(610, 70);
    wait_pulse(200, n);
    check_value("c0_rdrop_row", 32'(Aliens_Row), 50);
    check_value("c0_rdrop_dir", 32'(Moving_Right), 0);
    march_to_col(10, 70);
    wait_pulse(200, n);
    check_value("c0_left_col", 32'(Aliens_Col), 0);
    wait_pulse(200, n);
    check_value("c0_ldrop_row", 32'(Aliens_Row), 60);
    check_value("c0_ldrop_col", 32'(Aliens_Col), 0);
    check_value("c0_ldrop_dir", 32'(Moving_Right), 1);

    // Kill down to one alien two clocks into a period.
    wait_pulse(200, n);
    repeat (2) @(negedge Clk);
    Aliens_Grid = 50'd1;
    wait_pulse(200, n);
    check_value("kill_gap", n + 2, 6);
    check_value("kill_col", 32'(Aliens_Col), 20);

    // Grid emptied while marching.
    repeat (3) @(negedge Clk);
    Aliens_Grid = '0;
    @(negedge Clk);
    check_value("clr_cleared", 32'(Cleared), 1);
    check_value("clr_invaded", 32'(Invaded), 0);
    count_pulses(40, pulses);
    check_value("clr_no_step", pulses, 0);
    check_value("clr_hold_col", 32'(Aliens_Col), 20);

    // Only row 4 alive, player at 200: invades once Row reaches 60.
    Start = 1'b0; Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    Aliens_Grid = 50'h3FF << 40; Player_Row = 9'd200; Start = 1'b1;
    n = 0;
    while (!Invaded && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    check_value("inv_flag", 32'(Invaded), 1);
    check_value("inv_cleared", 32'(Cleared), 0);
    check_value("inv_row", 32'(Aliens_Row), 60);
    count_pulses(40, pulses);
    check_value("inv_no_step", pulses, 0);
    check_value("inv_hold_col", 32'(Aliens_Col), 0);
    check_value("inv_hold_row", 32'(Aliens_Row), 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
